// File: rtl/nor_chk_pkg.sv
// nor_chk_pkg: shared FSM states, vector count, widths and reference model for the NOR checker
package nor_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } chk_state_t;

    localparam int NUM_VECTORS = 4;
    localparam int ERR_W       = 3;
    localparam int IDX_W       = 2;
    localparam int CNT_W       = 4;

    function automatic logic nor_ref(input logic a, input logic b);
        return ~(a | b);
    endfunction

endpackage

// File: rtl/nor_exhaustive_checker_settle_timer.sv
// settle_timer: loadable down-counter that reports when the settle window has elapsed
module settle_timer
    import nor_chk_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             tick_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;

    // load wins over tick; the count parks at zero
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (tick_i && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/nor_exhaustive_checker.sv
// nor_exhaustive_checker: drives all four input vectors into a NOR gate and scores its output
module nor_exhaustive_checker
    import nor_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail,
    output logic             fail_valid
);

    chk_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0]       ff_q, ff_d;
    logic             fv_q, fv_d;
    logic             load, tick, expired, mis;

    // the vector index doubles as {a,b}, so a and b only move when DRIVE is entered
    assign mis = (y !== nor_ref(idx_q[1], idx_q[0]));

    settle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .load_val_i (CNT_W'(SETTLE_CYCLES - 1)),
        .tick_i     (tick),
        .expired_o  (expired)
    );

    // next-state, scoring and settle-timer control
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fv_d    = fv_q;
        load    = 1'b0;
        tick    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                    load    = 1'b1;
                end
            end
            DRIVE: begin
                if (expired)
                    state_d = SAMPLE;
                else
                    tick = 1'b1;
            end
            SAMPLE: begin
                if (mis) begin
                    err_d = err_q + 1'b1;
                    ff_d  = fv_q ? ff_q : idx_q;
                    fv_d  = 1'b1;
                end
                if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 1'b1;
                    load    = 1'b1;
                end
            end
        endcase
    end

    // state and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
        end
    end

    assign a          = idx_q[1];
    assign b          = idx_q[0];
    assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign fail_valid = fv_q;

endmodule

// File: tb/tb_nor_exhaustive_checker.sv
// tb_nor_exhaustive_checker: directed checks of the NOR checker against good and faulty gate models
module tb_nor_exhaustive_checker;
    import nor_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a, b, y, busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] first_fail;
    int         mode = 0;
    int         checks = 0;
    int         errors = 0;
    int         cyc;

    always #5 clk = ~clk;

    // gate under test: 0 good NOR, 1 stuck-at-0, 2 stuck-at-1, 3 OR
    assign y = (mode == 0) ? ~(a | b) : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (a | b);

    nor_exhaustive_checker #(.SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_valid (fail_valid)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_results(input string tag, input int ec, input int ff, input int fv, input int ps);
        chk({tag, " done"}, int'(done), 1);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " err_count"}, int'(err_count), ec);
        if (fv != 0) chk({tag, " first_fail"}, int'(first_fail), ff);
        chk({tag, " fail_valid"}, int'(fail_valid), fv);
        chk({tag, " pass"}, int'(pass), ps);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ab"}, int'({a, b}), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " pass"}, int'(pass), 0);
        chk({tag, " err_count"}, int'(err_count), 0);
        chk({tag, " first_fail"}, int'(first_fail), 0);
        chk({tag, " fail_valid"}, int'(fail_valid), 0);
        chk({tag, " state"}, int'(dut.state_q), int'(IDLE));
    endtask

    // pulses start for one cycle (optionally again mid-run) and counts edges until done
    task automatic run(input bit mid, output int cycles);
        int n = 0;
        start = 1'b1;
        cycles = -1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (mid && n == 5) start = 1'b1;
            if (mid && n == 6) start = 1'b0;
            if (done) begin
                cycles = n;
                break;
            end
            if (n % 3 == 1) chk("vector ab", int'({a, b}), (n - 1) / 3);
            chk("busy in run", int'(busy), 1);
        end
        chk("run cycles", cycles, 13);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        mode = 0;
        run(1'b0, cyc);
        chk_results("good", 0, 0, 0, 1);

        mode = 1;
        run(1'b0, cyc);
        chk_results("stuck0", 1, 0, 1, 0);

        mode = 2;
        run(1'b0, cyc);
        chk_results("stuck1", 3, 1, 1, 0);

        mode = 3;
        run(1'b0, cyc);
        chk_results("or", 4, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk_results("or hold", 4, 0, 1, 0);

        mode = 0;
        run(1'b0, cyc);
        chk_results("restart good", 0, 0, 0, 1);

        mode = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid-run ab", int'({a, b}), 2);
        chk("mid-run busy", int'(busy), 1);
        chk("mid-run err_count", int'(err_count), 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_zero("mid-run reset");
        mode = 0;
        run(1'b0, cyc);
        chk_results("after reset", 0, 0, 0, 1);

        run(1'b1, cyc);
        chk_results("start during busy", 0, 0, 0, 1);

        begin
            int hits = 0;
            int first_hit = 0;
            int second_hit = 0;
            start = 1'b1;
            for (int n = 1; n <= 30; n++) begin
                @(negedge clk);
                if (done) begin
                    hits++;
                    if (hits == 1) first_hit = n;
                    if (hits == 2) second_hit = n;
                end
            end
            start = 1'b0;
            chk("held start done count", hits, 2);
            chk("held start first done", first_hit, 13);
            chk("held start second done", second_hit, 26);
            cyc = -1;
            for (int n = 1; n <= 40; n++) begin
                @(negedge clk);
                if (done) begin
                    cyc = n;
                    break;
                end
            end
            chk("held start final run ends", int'(cyc > 0), 1);
            chk_results("held start final", 0, 0, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
